// File: rtl/multiplexor_display.sv
// Time-multiplexed common-anode 7-segment driver with a blank guard between digits.
// Optional leading-zero suppression is enabled by defining SUPRIMIR_CEROS_EN.
module multiplexor_display #(
    parameter int NUM_DIGITOS    = 2,
    parameter int CICLOS_APAGADO = 4,
    localparam int DW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1
) (
    input  logic                     reloj,
    input  logic                     reset,
    input  logic                     contador_actualizar,
    input  logic [4*NUM_DIGITOS-1:0] valor_bcd,
    output logic [NUM_DIGITOS-1:0]   anodos,
    output logic [6:0]               segmentos,
    output logic [DW-1:0]            digito_activo
);

    localparam int CW = (CICLOS_APAGADO > 1) ? $clog2(CICLOS_APAGADO) : 1;

    localparam logic [1:0] REPOSO  = 2'd0;
    localparam logic [1:0] MOSTRAR = 2'd1;
    localparam logic [1:0] APAGADO = 2'd2;

    logic [1:0]             estado, estado_sig;
    logic [CW-1:0]          cuenta, cuenta_sig;
    logic [DW-1:0]          digito_sig;
    logic                   sinc1, sinc2, sinc3, paso;
    logic [NUM_DIGITOS-1:0] anodos_sig;
    logic [6:0]             segmentos_sig;
    logic [3:0]             digito_sel;
`ifdef SUPRIMIR_CEROS_EN
    logic [NUM_DIGITOS:0]   ceros_arriba;
`endif

    function automatic logic [6:0] decodificar(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decodificar = 7'h40;
            4'd1:    decodificar = 7'h79;
            4'd2:    decodificar = 7'h24;
            4'd3:    decodificar = 7'h30;
            4'd4:    decodificar = 7'h19;
            4'd5:    decodificar = 7'h12;
            4'd6:    decodificar = 7'h02;
            4'd7:    decodificar = 7'h78;
            4'd8:    decodificar = 7'h00;
            4'd9:    decodificar = 7'h10;
            default: decodificar = 7'h3F;
        endcase
    endfunction

    // Toggle crosses clock domains; paso is registered so the step lands three edges after sampling.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            sinc1 <= 1'b0;
            sinc2 <= 1'b0;
            sinc3 <= 1'b0;
            paso  <= 1'b0;
        end else begin
            sinc1 <= contador_actualizar;
            sinc2 <= sinc1;
            sinc3 <= sinc2;
            paso  <= sinc2 ^ sinc3;
        end
    end

    always_comb begin
        estado_sig = estado;
        cuenta_sig = cuenta;
        digito_sig = digito_activo;
        case (estado)
            REPOSO: begin
                if (paso) begin
                    estado_sig = APAGADO;
                    cuenta_sig = CW'(CICLOS_APAGADO - 1);
                end
            end
            MOSTRAR: begin
                if (paso) begin
                    estado_sig = APAGADO;
                    cuenta_sig = CW'(CICLOS_APAGADO - 1);
                    digito_sig = (digito_activo == DW'(NUM_DIGITOS - 1)) ? '0 : digito_activo + 1'b1;
                end
            end
            APAGADO: begin
                if (cuenta == '0)
                    estado_sig = MOSTRAR;
                else
                    cuenta_sig = cuenta - 1'b1;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    // Outputs are derived from the next state so anodes and segments switch on the same edge.
    always_comb begin
        anodos_sig    = '1;
        segmentos_sig = 7'h7F;
        digito_sel    = 4'd0;
`ifdef SUPRIMIR_CEROS_EN
        ceros_arriba[NUM_DIGITOS] = 1'b1;
        for (int i = NUM_DIGITOS - 1; i >= 0; i--)
            ceros_arriba[i] = ceros_arriba[i+1] && (valor_bcd[4*i +: 4] == 4'd0);
`endif
        if (estado_sig == MOSTRAR) begin
            for (int i = 0; i < NUM_DIGITOS; i++) begin
                if (DW'(i) == digito_sig) begin
                    digito_sel    = valor_bcd[4*i +: 4];
                    anodos_sig[i] = 1'b0;
                    segmentos_sig = decodificar(valor_bcd[4*i +: 4]);
`ifdef SUPRIMIR_CEROS_EN
                    if (i > 0 && ceros_arriba[i]) begin
                        anodos_sig[i] = 1'b1;
                        segmentos_sig = 7'h7F;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            estado        <= REPOSO;
            cuenta        <= '0;
            digito_activo <= '0;
            anodos        <= '1;
            segmentos     <= 7'h7F;
        end else begin
            estado        <= estado_sig;
            cuenta        <= cuenta_sig;
            digito_activo <= digito_sig;
            anodos        <= anodos_sig;
            segmentos     <= segmentos_sig;
        end
    end

    logic unused_sel;
    assign unused_sel = ^digito_sel;

endmodule

// File: tb/tb_multiplexor_display.sv
// Directed self-checking bench for multiplexor_display (2 digits, 4 guard cycles).
module tb_multiplexor_display;

    logic       reloj = 1'b0;
    logic       reset;
    logic       contador_actualizar;
    logic [7:0] valor_bcd;
    logic [1:0] anodos;
    logic [6:0] segmentos;
    logic [0:0] digito_activo;

    int n_cmp = 0;
    int n_err = 0;

    multiplexor_display #(.NUM_DIGITOS(2), .CICLOS_APAGADO(4)) dut (
        .reloj               (reloj),
        .reset               (reset),
        .contador_actualizar (contador_actualizar),
        .valor_bcd           (valor_bcd),
        .anodos              (anodos),
        .segmentos           (segmentos),
        .digito_activo       (digito_activo)
    );

    always #5 reloj = ~reloj;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge reloj);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 50; c++) begin
            tick();
            n_cmp++;
            if ({anodos, segmentos, digito_activo} !== {2'b11, 7'h7F, 1'b0}) begin
                n_err++;
                $display("[TB] FAIL reset_hold cyc=%0d got an=%b seg=%h dig=%0d want an=11 seg=7f dig=0",
                         c, anodos, segmentos, digito_activo);
            end
        end
    endtask

    // Toggle, then expect: ticks 1-3 previous display, 4-7 blank, 8 new digit.
    task automatic test_step(input string nombre, input logic [1:0] an_prev, input logic [6:0] seg_prev,
                             input logic [1:0] an_new, input logic [6:0] seg_new, input logic dig_new);
        contador_actualizar = ~contador_actualizar;
        for (int t = 1; t <= 10; t++) begin
            logic [1:0] ea;
            logic [6:0] es;
            tick();
            if (t <= 3) begin
                ea = an_prev; es = seg_prev;
            end else if (t <= 7) begin
                ea = 2'b11; es = 7'h7F;
            end else begin
                ea = an_new; es = seg_new;
            end
            n_cmp++;
            if ({anodos, segmentos} !== {ea, es}) begin
                n_err++;
                $display("[TB] FAIL %s t=%0d got an=%b seg=%h want an=%b seg=%h",
                         nombre, t, anodos, segmentos, ea, es);
            end
            if (t >= 4) begin
                n_cmp++;
                if (digito_activo !== dig_new) begin
                    n_err++;
                    $display("[TB] FAIL %s_dig t=%0d got %0d want %0d", nombre, t, digito_activo, dig_new);
                end
            end
        end
    endtask

    task automatic test_live_update();
        valor_bcd = 8'h0C;
        tick();
        n_cmp++;
        if ({anodos, segmentos} !== {2'b10, 7'h3F}) begin
            n_err++;
            $display("[TB] FAIL live_dash got an=%b seg=%h want an=10 seg=3f", anodos, segmentos);
        end
        valor_bcd = 8'h07;
        tick();
        n_cmp++;
        if ({anodos, segmentos} !== {2'b10, 7'h78}) begin
            n_err++;
            $display("[TB] FAIL live_seven got an=%b seg=%h want an=10 seg=78", anodos, segmentos);
        end
        valor_bcd = 8'h15;
        tick();
    endtask

    task automatic test_back_to_back();
        contador_actualizar = ~contador_actualizar;
        for (int t = 1; t <= 14; t++) begin
            logic [1:0] ea;
            logic [6:0] es;
            logic       ed;
            tick();
            if (t == 2) contador_actualizar = ~contador_actualizar;
            if (t <= 3) begin
                ea = 2'b10; es = 7'h12; ed = 1'b0;
            end else if (t <= 7) begin
                ea = 2'b11; es = 7'h7F; ed = 1'b1;
            end else begin
                ea = 2'b01; es = 7'h79; ed = 1'b1;
            end
            n_cmp++;
            if ({anodos, segmentos, digito_activo} !== {ea, es, ed}) begin
                n_err++;
                $display("[TB] FAIL back_to_back t=%0d got an=%b seg=%h dig=%0d want an=%b seg=%h dig=%0d",
                         t, anodos, segmentos, digito_activo, ea, es, ed);
            end
        end
    endtask

    task automatic test_suppress();
        logic [1:0] ea;
        logic [6:0] es;
        valor_bcd = 8'h03;
        tick();
`ifdef SUPRIMIR_CEROS_EN
        ea = 2'b11; es = 7'h7F;
`else
        ea = 2'b01; es = 7'h40;
`endif
        n_cmp++;
        if ({anodos, segmentos, digito_activo} !== {ea, es, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL leading_zero got an=%b seg=%h dig=%0d want an=%b seg=%h dig=1",
                     anodos, segmentos, digito_activo, ea, es);
        end
        test_step("suppress_wrap", ea, es, 2'b10, 7'h30, 1'b0);
    endtask

    task automatic test_reset_mid();
        contador_actualizar = ~contador_actualizar;
        for (int t = 0; t < 5; t++) tick();
        n_cmp++;
        if ({anodos, digito_activo} !== {2'b11, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL pre_reset_blank got an=%b dig=%0d want an=11 dig=1", anodos, digito_activo);
        end
        reset = 1'b1;
        contador_actualizar = 1'b0;
        #1;
        n_cmp++;
        if ({anodos, segmentos, digito_activo} !== {2'b11, 7'h7F, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL reset_mid_blank got an=%b seg=%h dig=%0d want an=11 seg=7f dig=0",
                     anodos, segmentos, digito_activo);
        end
        tick();
        reset = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            n_cmp++;
            if ({anodos, segmentos, digito_activo} !== {2'b11, 7'h7F, 1'b0}) begin
                n_err++;
                $display("[TB] FAIL post_reset_idle t=%0d got an=%b seg=%h dig=%0d", t, anodos, segmentos,
                         digito_activo);
            end
        end
        test_step("restart", 2'b11, 7'h7F, 2'b10, 7'h30, 1'b0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({anodos, segmentos, digito_activo} !== {2'b11, 7'h7F, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL reset_mid_show got an=%b seg=%h dig=%0d want an=11 seg=7f dig=0",
                     anodos, segmentos, digito_activo);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset               = 1'b1;
        contador_actualizar = 1'b0;
        valor_bcd           = 8'h15;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_step("first_step", 2'b11, 7'h7F, 2'b10, 7'h12, 1'b0);
        test_step("advance", 2'b10, 7'h12, 2'b01, 7'h79, 1'b1);
        test_step("wrap", 2'b01, 7'h79, 2'b10, 7'h12, 1'b0);
        test_live_update();
        test_back_to_back();
        test_suppress();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
